// File: rtl/sum_drv_pkg.sv
// Shared types, default parameters and the reference sum helper for the
// adder-interface operand driver.
package sum_drv_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_LATENCY = 1;

    // Widest operand the reference sum helper supports.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Full-precision sum with carry; callers zero-extend their operands to
    // MAX_W bits and keep the low WIDTH+1 bits of the result.
    function automatic logic [MAX_W:0] exp_sum(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/sum_drv_fifo.sv
// Synchronous operand FIFO. The caller guarantees that it never pushes
// when full and never pops when empty.
module sum_drv_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DW-1:0]                wdata_i,
    output logic [DW-1:0]                rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next occupancy from the push/pop pair.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves count_d unassigned (which would infer a latch).
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; empty slots are never read because count gates every pop.
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sum_operand_driver.sv
// Initiator for a registered adder: buffers operand pairs, issues one pair
// at a time, waits the adder latency, captures the result and returns it
// with carry and a self-check flag on a valid/ready stream.
module sum_operand_driver
    import sum_drv_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_a,
    input  logic [WIDTH-1:0]             s_b,
    output logic [WIDTH-1:0]             sum_a,
    output logic [WIDTH-1:0]             sum_b,
    input  logic [WIDTH-1:0]             sum_c,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_a,
    output logic [WIDTH-1:0]             m_b,
    output logic [WIDTH-1:0]             m_c,
    output logic                         m_ovf,
    output logic                         m_err,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CW    = $clog2(DEPTH+1);
    localparam int WCW   = $clog2(LATENCY+1);

    state_t           state_q;
    logic [WCW-1:0]   wcnt_q;
    logic [WIDTH-1:0] sum_a_q, sum_b_q;
    logic [WIDTH-1:0] m_a_q, m_b_q, m_c_q;
    logic             m_ovf_q, m_err_q, m_valid_q;

    logic             push, pop;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0] head_a, head_b;
    logic [WIDTH:0]   ref_sum;

    // Space is judged from the registered count only, so a pop never frees
    // a slot in the same cycle.
    assign s_ready = (fifo_count < CW'(DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == IDLE) && (fifo_count != '0);

    sum_drv_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({s_a, s_b}),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    assign head_a  = head[2*WIDTH-1:WIDTH];
    assign head_b  = head[WIDTH-1:0];
    assign ref_sum = (WIDTH+1)'(exp_sum(MAX_W'(m_a_q), MAX_W'(m_b_q)));

    // Issue / wait / respond sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            sum_a_q   <= '0;
            sum_b_q   <= '0;
            m_a_q     <= '0;
            m_b_q     <= '0;
            m_c_q     <= '0;
            m_ovf_q   <= 1'b0;
            m_err_q   <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sum_a_q <= head_a;
                        sum_b_q <= head_b;
                        m_a_q   <= head_a;
                        m_b_q   <= head_b;
                        wcnt_q  <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt_q == WCW'(LATENCY)) begin
                        m_c_q     <= sum_c;
                        m_ovf_q   <= ref_sum[WIDTH];
                        m_err_q   <= (sum_c != ref_sum[WIDTH-1:0]);
                        m_valid_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        wcnt_q <= wcnt_q + WCW'(1);
                    end
                end
                RESP: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sum_a   = sum_a_q;
    assign sum_b   = sum_b_q;
    assign m_a     = m_a_q;
    assign m_b     = m_b_q;
    assign m_c     = m_c_q;
    assign m_ovf   = m_ovf_q;
    assign m_err   = m_err_q;
    assign m_valid = m_valid_q;

endmodule
